// File: rtl/exe_pkg.sv
// Shared opcode constants, ALU operation encoding and FSM states for the
// pipelined execute stage.
package exe_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_GTU  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIVU = 4'd7;

    localparam logic [5:0] OP_BEQZ = 6'b110100;
    localparam logic [5:0] OP_BNEZ = 6'b110101;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_AND,
        ALU_OR,
        ALU_GTU,
        ALU_MUL,
        ALU_DIVU,
        ALU_ZERO
    } alu_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    // Memory/branch opcodes (bit 5 set) always use the adder for the address.
    function automatic alu_op_e decode_alu(input logic [5:0] opcode);
        if (opcode[5]) begin
            return ALU_ADD;
        end
        case (opcode[3:0])
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_GTU:  return ALU_GTU;
            OP_MUL:  return ALU_MUL;
            OP_DIVU: return ALU_DIVU;
            default: return ALU_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per
// step; result is exposed combinationally so the final step can be consumed directly.
module iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic            abort,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    // acc: running product (MUL) or partial remainder (DIV)
    // x:   multiplier shifting right (MUL) or dividend/quotient shifting left (DIV)
    // y:   multiplicand shifting left (MUL) or fixed divisor (DIV)
    logic [CW-1:0]   count_reg;
    logic [XLEN:0]   acc_reg, acc_next;
    logic [XLEN-1:0] x_reg, x_next;
    logic [XLEN-1:0] y_reg, y_next;
    logic            div_reg;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        acc_next = acc_reg;
        x_next   = x_reg;
        y_next   = y_reg;
        rem_sh   = {acc_reg[XLEN-1:0], x_reg[XLEN-1]};
        diff     = rem_sh - {1'b0, y_reg};
        if (div_reg) begin
            // A zero divisor never goes negative, so every quotient bit sets.
            if (!diff[XLEN]) begin
                acc_next = diff;
                x_next   = {x_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_next = rem_sh;
                x_next   = {x_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {1'b0, acc_reg[XLEN-1:0] + (x_reg[0] ? y_reg : '0)};
            x_next   = x_reg >> 1;
            y_next   = y_reg << 1;
        end
    end

    assign last   = (count_reg == CW'(XLEN - 1));
    assign result = div_reg ? x_next : acc_next[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            acc_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            div_reg   <= 1'b0;
        end else if (abort) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
            acc_reg   <= '0;
            x_reg     <= op_a;
            y_reg     <= op_b;
            div_reg   <= is_div;
        end else if (step) begin
            acc_reg   <= acc_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            count_reg <= last ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/exe_stage_pipe.sv
// Pipelined execute stage: single-cycle ALU/branch path plus iterative MUL/DIVU,
// with valid/ready on both sides and an EX/MEM output register.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] npc,
    input  logic [31:0]     ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     ir_ex,
    output logic [XLEN-1:0] alu_res,
    output logic [XLEN-1:0] b_ex,
    output logic [XLEN-1:0] npc_ex,
    output logic            cond
);

    logic [5:0]      opcode;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] target;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_val;
    logic            cond_val;
    logic            is_iter;

    state_e          state_reg, state_next;
    logic            slot_free;
    logic            accept;
    logic            start_iter;
    logic            load_single;
    logic            load_iter;
    logic            md_step;
    logic            md_last;
    logic [XLEN-1:0] md_result;

    logic [31:0]     ir_hold_reg;
    logic [XLEN-1:0] b_hold_reg;
    logic [XLEN-1:0] target_hold_reg;

    logic            out_valid_reg;
    logic [31:0]     ir_ex_reg;
    logic [XLEN-1:0] alu_res_reg;
    logic [XLEN-1:0] b_ex_reg;
    logic [XLEN-1:0] npc_ex_reg;
    logic            cond_reg;

    assign opcode  = ir[31:26];
    assign op2     = opcode[4] ? imm : b;
    assign target  = npc + imm;
    assign alu_op  = decode_alu(opcode);
    assign is_iter = (alu_op == ALU_MUL) || (alu_op == ALU_DIVU);

    always_comb begin
        alu_val = '0;
        case (alu_op)
            ALU_ADD: alu_val = a + op2;
            ALU_SUB: alu_val = a - op2;
            ALU_XOR: alu_val = a ^ op2;
            ALU_AND: alu_val = a & op2;
            ALU_OR:  alu_val = a | op2;
            ALU_GTU: alu_val = {{(XLEN-1){1'b0}}, (a > op2)};
            default: alu_val = '0;
        endcase
    end

    // BEQZ and BNEZ differ only in bit 0, which inverts the zero test.
    assign cond_val = (opcode[5:1] == OP_BEQZ[5:1]) ? (opcode[0] ^ (a == '0)) : 1'b0;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = rst_n && (state_reg == IDLE) && slot_free && !flush;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A finished MUL/DIV parks on its last step until the output slot frees.
    always_comb begin
        state_next  = state_reg;
        start_iter  = 1'b0;
        load_single = 1'b0;
        load_iter   = 1'b0;
        md_step     = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_iter) begin
                            start_iter = 1'b1;
                            state_next = BUSY;
                        end else begin
                            load_single = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!md_last) begin
                        md_step = 1'b1;
                    end else if (slot_free) begin
                        md_step    = 1'b1;
                        load_iter  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    iter_muldiv #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_iter),
        .step   (md_step),
        .abort  (flush),
        .is_div (alu_op == ALU_DIVU),
        .op_a   (a),
        .op_b   (op2),
        .last   (md_last),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_hold_reg     <= '0;
            b_hold_reg      <= '0;
            target_hold_reg <= '0;
        end else if (start_iter) begin
            ir_hold_reg     <= ir;
            b_hold_reg      <= b;
            target_hold_reg <= target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            ir_ex_reg     <= '0;
            alu_res_reg   <= '0;
            b_ex_reg      <= '0;
            npc_ex_reg    <= '0;
            cond_reg      <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load_single) begin
            out_valid_reg <= 1'b1;
            ir_ex_reg     <= ir;
            alu_res_reg   <= alu_val;
            b_ex_reg      <= b;
            npc_ex_reg    <= target;
            cond_reg      <= cond_val;
        end else if (load_iter) begin
            out_valid_reg <= 1'b1;
            ir_ex_reg     <= ir_hold_reg;
            alu_res_reg   <= md_result;
            b_ex_reg      <= b_hold_reg;
            npc_ex_reg    <= target_hold_reg;
            cond_reg      <= 1'b0;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign ir_ex     = ir_ex_reg;
    assign alu_res   = alu_res_reg;
    assign b_ex      = b_ex_reg;
    assign npc_ex    = npc_ex_reg;
    assign cond      = cond_reg;

endmodule

// File: doc/exe_stage_pipe.md
# exe_stage_pipe

Parametrised, pipelined successor to the combinational execute stage. Accepts a decoded instruction from ID through a valid/ready handshake, computes ALU, load/store address, branch target and condition, and holds the result in an EX/MEM output register with its own valid/ready handshake. Adds iterative multi-cycle MUL and DIV, back-pressure toward ID, and a pipeline flush.

## Interface
- XLEN, 32, datapath width of operands, immediate, NPC and results (≥8)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of in-flight and registered work
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage accepts this cycle
- a, b, imm, npc  in  XLEN  register operands, sign-extended immediate, next PC
- ir  in  32  instruction; opcode = ir[31:26]
- out_valid  out  1  EX/MEM register holds a result
- out_ready  in  1  MEM consumes the result this cycle
- ir_ex  out  32  registered ir
- alu_res  out  XLEN  registered result
- b_ex  out  XLEN  registered b (store data)
- npc_ex  out  XLEN  registered npc+imm (branch target)
- cond  out  1  registered branch-taken flag

## Operation
- Operand select: op2 = opcode[4] ? imm : b.
- opcode[5]=0, by opcode[3:0]: 0 add, 1 sub, 2 xor, 3 and, 4 or, 5 unsigned a>op2 → 1 else 0, 6 MUL (low XLEN bits, unsigned), 7 DIVU (quotient); 8–15 → 0.
- opcode[5]=1: alu_res = a+op2 (load/store/branch address).
- cond = 1 only for opcode[5:1]=11010: opcode[0] ^ (a==0). BEQZ 110100 taken on a==0; BNEZ 110101 taken on a!=0. Otherwise 0.
- npc_ex = npc+imm, modulo 2^XLEN; all adds/subs wrap, no flags.
- DIVU by zero: quotient all-ones. MUL/DIV never trap.
- FSM: IDLE, BUSY.
  - IDLE: handshake with single-cycle op → load output register. Handshake with MUL/DIV → latch operands, ir, npc, imm, b; counter=0; go BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. At counter=XLEN-1 load output register with the result, go IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Output register: cleared (out_valid=0) when out_valid && out_ready and no new load; a new load the same cycle overwrites.
- flush (priority over all): out_valid←0, BUSY→IDLE, counter←0, no input accepted that cycle.
- Reset: state IDLE, out_valid 0, ir_ex/alu_res/b_ex/npc_ex 0, cond 0, counter 0; in_ready 1 once rst_n high (0 while low). Reset mid-BUSY discards the operation.

## Timing
- Single-cycle ops: accepted at edge N, out_valid at N+1.
- MUL/DIV: accepted at N, BUSY for XLEN cycles, out_valid at N+XLEN+1; in_ready 0 throughout.
- Back-pressure: out_valid && !out_ready stalls in_ready; outputs stable until consumed.
- Full throughput: single-cycle ops back-to-back at one per cycle when out_ready=1.
- BUSY completion while output register full and not consumed: FSM holds in BUSY at final step until slot frees (no result lost).

## Structure
- Package exe_pkg: opcode field constants (OP_ADD..OP_DIVU, OP_BEQZ, OP_BNEZ), ALU op enum, FSM state enum (IDLE, BUSY).
- Sub-module iter_muldiv: XLEN-parametrised iterative multiplier/unsigned divider with start/done, step counter, abort input driven by flush.
- Top: operand mux, single-cycle ALU, branch logic, FSM, output register.

## Test plan
- Reset, then ADD a=5,b=7 (opcode 000000) → next cycle out_valid=1, alu_res=12, cond=0.
- ADDI a=0xFFFFFFFF, imm=1 (opcode 010000) → alu_res=0; npc=0x100, imm=0x10 → npc_ex=0x110.
- BEQZ a=0 → cond=1; BNEZ a=0 → cond=0; BNEZ a=3 → cond=1.
- MUL a=6,b=7 → in_ready low XLEN cycles, alu_res=42 at N+XLEN+1; DIVU 100/7 → 14; DIVU 9/0 → 0xFFFFFFFF.
- out_ready=0 for 3 cycles after SUB 10-3 → alu_res=7 held, in_ready=0, no input lost; back-to-back ADDs with out_ready=1 → one result per cycle.
- flush during BUSY of MUL → out_valid stays 0, in_ready=1 next cycle; rst_n low mid-DIV → all outputs 0 asynchronously.
